// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - PS/2 byte decoder, board cursor and select/confirm handshake
// Optional feature macro: CURSOR_WRAP_EN (cursor wraps at board edges instead of saturating).
module cursor_ctrl #(
  parameter int         X_BITS    = 3,
  parameter int         Y_BITS    = 3,
  parameter int         X_MAX     = 7,
  parameter int         Y_MAX     = 7,
  parameter int         X_INIT    = 0,
  parameter int         Y_INIT    = 1,
  parameter logic [7:0] KEY_UP    = 8'h1D,
  parameter logic [7:0] KEY_DOWN  = 8'h1B,
  parameter logic [7:0] KEY_LEFT  = 8'h1C,
  parameter logic [7:0] KEY_RIGHT = 8'h23,
  parameter logic [7:0] KEY_ENTER = 8'h5A,
  parameter logic [7:0] KEY_ESC   = 8'h76
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     code_valid,
  input  logic [7:0]               code,
  input  logic                     busy,
  input  logic                     own_piece,
  input  logic                     move_ok,
  output logic [X_BITS+Y_BITS-1:0] cursor,
  output logic                     sel_valid,
  output logic [X_BITS+Y_BITS-1:0] sel_pos,
  output logic                     confirm,
  output logic [X_BITS+Y_BITS-1:0] confirm_src,
  output logic [X_BITS+Y_BITS-1:0] confirm_dst,
  output logic                     cancel,
  output logic                     key_evt
);
  localparam int P_BITS = X_BITS + Y_BITS;
  localparam logic [X_BITS-1:0] XM = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] YM = Y_BITS'(Y_MAX);
`ifdef CURSOR_WRAP_EN
  localparam logic [X_BITS-1:0] X_OVER  = '0;
  localparam logic [X_BITS-1:0] X_UNDER = XM;
  localparam logic [Y_BITS-1:0] Y_OVER  = '0;
  localparam logic [Y_BITS-1:0] Y_UNDER = YM;
`else
  localparam logic [X_BITS-1:0] X_OVER  = XM;
  localparam logic [X_BITS-1:0] X_UNDER = '0;
  localparam logic [Y_BITS-1:0] Y_OVER  = YM;
  localparam logic [Y_BITS-1:0] Y_UNDER = '0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_COMMIT} state_e;

  state_e              state_q, state_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [7:0]          held_q, held_d;
  logic [X_BITS-1:0]   x_q, x_d;
  logic [Y_BITS-1:0]   y_q, y_d;
  logic [P_BITS-1:0]   sel_pos_q, sel_pos_d, src_q, src_d, dst_q, dst_d;
  logic                sel_valid_q, sel_valid_d, confirm_q, confirm_d;
  logic                cancel_q, cancel_d, key_evt_q, key_evt_d;
  logic                is_event, is_make, is_arrow, is_cmd, act;
  logic [P_BITS-1:0]   cur_pos;
  logic                ext_unused;

  // The E0 prefix is tracked but key matching deliberately ignores it.
  assign ext_unused = ext_q;
  assign cur_pos    = {y_q, x_q};

  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    x_d         = x_q;
    y_d         = y_q;
    sel_pos_d   = sel_pos_q;
    src_d       = src_q;
    dst_d       = dst_q;
    confirm_d   = 1'b0;
    cancel_d    = 1'b0;
    key_evt_d   = 1'b0;
    is_event    = code_valid && (code != 8'hE0) && (code != 8'hF0);
    is_make     = is_event && !brk_q;
    is_arrow    = (code == KEY_UP) || (code == KEY_DOWN) ||
                  (code == KEY_LEFT) || (code == KEY_RIGHT);
    is_cmd      = (code == KEY_ENTER) || (code == KEY_ESC);
    // Arrows repeat with typematic; ENTER/ESC fire once per press.
    act         = is_make && (is_arrow || (is_cmd && (code != held_q))) &&
                  !busy && (state_q != ST_COMMIT);

    if (code_valid) begin
      if (code == 8'hE0)      ext_d = 1'b1;
      else if (code == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (is_event && brk_q && (code == held_q)) held_d = '0;
    if (is_make && is_cmd) held_d = code;
    if (state_q == ST_COMMIT) state_d = ST_IDLE;

    if (act) begin
      key_evt_d = 1'b1;
      if (code == KEY_UP)         y_d = (y_q == YM)  ? Y_OVER  : y_q + 1'b1;
      else if (code == KEY_DOWN)  y_d = (y_q == '0)  ? Y_UNDER : y_q - 1'b1;
      else if (code == KEY_RIGHT) x_d = (x_q == XM)  ? X_OVER  : x_q + 1'b1;
      else if (code == KEY_LEFT)  x_d = (x_q == '0)  ? X_UNDER : x_q - 1'b1;
      else if (code == KEY_ENTER) begin
        if (state_q == ST_IDLE) begin
          if (own_piece) begin
            state_d   = ST_SEL;
            sel_pos_d = cur_pos;
          end
        end else if (cur_pos == sel_pos_q) begin
          state_d = ST_IDLE;
        end else if (move_ok) begin
          state_d   = ST_COMMIT;
          confirm_d = 1'b1;
          src_d     = sel_pos_q;
          dst_d     = cur_pos;
        end
      end else if (state_q == ST_SEL) begin
        state_d  = ST_IDLE;
        cancel_d = 1'b1;
      end
    end
    sel_valid_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= '0;
      x_q         <= X_BITS'(X_INIT);
      y_q         <= Y_BITS'(Y_INIT);
      sel_pos_q   <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      sel_valid_q <= 1'b0;
      confirm_q   <= 1'b0;
      cancel_q    <= 1'b0;
      key_evt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sel_pos_q   <= sel_pos_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      sel_valid_q <= sel_valid_d;
      confirm_q   <= confirm_d;
      cancel_q    <= cancel_d;
      key_evt_q   <= key_evt_d;
    end
  end

  assign cursor      = cur_pos;
  assign sel_valid   = sel_valid_q;
  assign sel_pos     = sel_pos_q;
  assign confirm     = confirm_q;
  assign confirm_src = src_q;
  assign confirm_dst = dst_q;
  assign cancel      = cancel_q;
  assign key_evt     = key_evt_q;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb/tb_cursor_ctrl.sv - directed and random bench for cursor_ctrl against a behavioural model
module tb_cursor_ctrl;
  localparam int XB = 3, XM = 7, YM = 7, XI = 0, YI = 1;

  logic       clk = 1'b0;
  logic       rst_n, code_valid, busy, own_piece, move_ok;
  logic [7:0] code;
  logic [5:0] cursor, sel_pos, confirm_src, confirm_dst;
  logic       sel_valid, confirm, cancel, key_evt;

  int n_checks = 0, n_err = 0, key_count = 0;

  int m_x, m_y, m_sx, m_sy, m_held;
  bit m_sel, m_commit, m_ext, m_brk;
  bit e_key, e_conf, e_cancel;
  int e_src, e_dst;

  always #5 clk = ~clk;

  cursor_ctrl dut (
    .clk(clk), .RST(rst_n), .code_valid(code_valid), .code(code), .busy(busy),
    .own_piece(own_piece), .move_ok(move_ok), .cursor(cursor), .sel_valid(sel_valid),
    .sel_pos(sel_pos), .confirm(confirm), .confirm_src(confirm_src),
    .confirm_dst(confirm_dst), .cancel(cancel), .key_evt(key_evt)
  );

  function automatic int pos(int x, int y);
    return (y << XB) + x;
  endfunction

  function automatic int inc(int v, int mx);
`ifdef CURSOR_WRAP_EN
    return (v + 1) % (mx + 1);
`else
    return (v < mx) ? v + 1 : mx;
`endif
  endfunction

  function automatic int dec(int v, int mx);
`ifdef CURSOR_WRAP_EN
    return (v + mx) % (mx + 1);
`else
    return (v > 0) ? v - 1 : 0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = XI; m_y = YI; m_sx = 0; m_sy = 0; m_held = 0;
    m_sel = 0; m_commit = 0; m_ext = 0; m_brk = 0;
    e_key = 0; e_conf = 0; e_cancel = 0;
  endtask

  task automatic model_step(bit v, logic [7:0] b);
    bit was_commit, brk, arrow, cmd, fire;
    was_commit = m_commit;
    e_key = 0; e_conf = 0; e_cancel = 0;
    if (m_commit) begin m_commit = 0; m_sel = 0; end
    if (!v) return;
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    brk = m_brk; m_brk = 0; m_ext = 0;
    if (brk) begin
      if (b == m_held) m_held = 0;
      return;
    end
    arrow = (b == 8'h1D) || (b == 8'h1B) || (b == 8'h1C) || (b == 8'h23);
    cmd   = (b == 8'h5A) || (b == 8'h76);
    if (!arrow && !cmd) return;
    fire = arrow || (b != m_held);
    if (cmd) m_held = b;
    if (!fire || busy || was_commit) return;
    e_key = 1;
    case (b)
      8'h1D: m_y = inc(m_y, YM);
      8'h1B: m_y = dec(m_y, YM);
      8'h23: m_x = inc(m_x, XM);
      8'h1C: m_x = dec(m_x, XM);
      8'h5A: begin
        if (!m_sel) begin
          if (own_piece) begin m_sel = 1; m_sx = m_x; m_sy = m_y; end
        end else if (m_x == m_sx && m_y == m_sy) begin
          m_sel = 0;
        end else if (move_ok) begin
          e_conf = 1; e_src = pos(m_sx, m_sy); e_dst = pos(m_x, m_y); m_commit = 1;
        end
      end
      default: if (m_sel) begin m_sel = 0; e_cancel = 1; end
    endcase
  endtask

  task automatic check_outputs();
    chk("cursor", cursor, pos(m_x, m_y));
    chk("sel_valid", sel_valid, m_sel);
    chk("sel_pos", sel_pos, pos(m_sx, m_sy));
    chk("confirm", confirm, e_conf);
    chk("cancel", cancel, e_cancel);
    chk("key_evt", key_evt, e_key);
    if (e_conf) begin
      chk("confirm_src", confirm_src, e_src);
      chk("confirm_dst", confirm_dst, e_dst);
    end
  endtask

  task automatic step(bit v, logic [7:0] b);
    code = b; code_valid = v;
    @(negedge clk);
    code_valid = 1'b0;
    model_step(v, b);
    if (key_evt === 1'b1) key_count++;
    check_outputs();
  endtask

  task automatic send(logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; code_valid = 1'b0; busy = 1'b0; own_piece = 1'b0; move_ok = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rst_cursor", cursor, pos(XI, YI));
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_pos", sel_pos, 0);
    chk("rst_confirm", confirm, 0);
    chk("rst_cancel", cancel, 0);
    chk("rst_key_evt", key_evt, 0);
    rst_n = 1'b1;
  endtask

  logic [7:0] pick [9];

  initial begin
    rst_n = 1'b0; code_valid = 1'b0; code = 8'h00;
    busy = 1'b0; own_piece = 1'b0; move_ok = 1'b0;
    pick = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h76, 8'h00};
    do_reset();

    // Two UP makes then an UP break
    key_count = 0;
    send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
    chk("up_twice_cursor", cursor, pos(0, 3));
    chk("up_twice_keys", key_count, 2);

    // Top edge
    repeat (4) send(8'h1D);
    chk("top_reached", cursor, pos(0, 7));
    send(8'h1D);
`ifdef CURSOR_WRAP_EN
    chk("top_edge", cursor, pos(0, 0));
`else
    chk("top_edge", cursor, pos(0, 7));
`endif

    // Select at {1,4}, commit to {3,4}
    do_reset();
    repeat (4) send(8'h23);
    own_piece = 1'b1;
    send(8'h5A);
    chk("select_valid", sel_valid, 1);
    chk("select_pos", sel_pos, pos(4, 1));
    own_piece = 1'b0;
    send(8'h1D); send(8'h1D);
    move_ok = 1'b1;
    send(8'hF0); send(8'h5A); send(8'h5A);
    chk("commit_pulse", confirm, 1);
    chk("commit_src", confirm_src, pos(4, 1));
    chk("commit_dst", confirm_dst, pos(4, 3));
    step(1'b0, 8'h00);
    chk("commit_done", confirm, 0);
    chk("commit_idle", sel_valid, 0);
    move_ok = 1'b0;

    // Held ENTER selects once; release and press again deselects
    own_piece = 1'b1;
    send(8'hF0); send(8'h5A);
    key_count = 0;
    send(8'h5A); send(8'h5A); send(8'h5A);
    chk("held_enter_keys", key_count, 1);
    chk("held_enter_sel", sel_valid, 1);
    send(8'hF0); send(8'h5A); send(8'h5A);
    chk("deselect", sel_valid, 0);

    // Extended ESC cancels; busy suppresses arrows
    send(8'hF0); send(8'h5A); send(8'h5A);
    chk("reselect", sel_valid, 1);
    send(8'hE0); send(8'h76);
    chk("cancel_pulse", cancel, 1);
    chk("cancel_desel", sel_valid, 0);
    own_piece = 1'b0;
    busy = 1'b1;
    send(8'h1C);
    chk("busy_cursor", cursor, pos(4, 3));
    chk("busy_key", key_evt, 0);
    busy = 1'b0;

    // Random traffic, including bytes that land during COMMIT
    for (int i = 0; i < 400; i++) begin
      busy      = ($urandom_range(0, 7) == 0);
      own_piece = $urandom_range(0, 1);
      move_ok   = $urandom_range(0, 1);
      code      = pick[$urandom_range(0, 8)];
      if (code == 8'h00) code = 8'($urandom);
      step($urandom_range(0, 3) != 0, code);
    end

    // Reset in the middle of a confirm pulse
    do_reset();
    own_piece = 1'b1;
    send(8'h5A);
    own_piece = 1'b0;
    send(8'h1D);
    move_ok = 1'b1;
    send(8'hF0); send(8'h5A); send(8'h5A);
    chk("pre_reset_confirm", confirm, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_confirm", confirm, 0);
    chk("async_cursor", cursor, pos(XI, YI));
    chk("async_sel_valid", sel_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; move_ok = 1'b0;
    model_reset();
    step(1'b0, 8'h00);
    send(8'h1B);
    chk("after_reset_move", cursor, pos(0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
